dbus_arbiter: RTL and testbench



---
 rtl/dbus_arbiter_pkg.sv | 22 ++
 rtl/dbus_arbiter_if.sv | 35 +++
 rtl/dbus_starve_cnt.sv | 49 ++++
 rtl/dbus_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_dbus_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/dbus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dbus_arbiter_pkg: shared state encoding and field widths for the data-bus arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dbus_arbiter_pkg;

  localparam int C_RLEN_W         = 3;
  localparam int C_WLEN_W         = 2;
  localparam int C_STARVE_W       = 4;
  localparam int C_STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BUSY_CORE = 2'd1,
    ST_BUSY_AUX  = 2'd2
  } arb_state_e;

endpackage : dbus_arbiter_pkg

`default_nettype wire

// File: rtl/dbus_arbiter_if.sv
// ---------------------------------------------------------------------------
// dbus_arbiter_if: registered req/ready data-memory bus driven by the arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dbus_arbiter_if
  import dbus_arbiter_pkg::*;
#(
  parameter int AW   = 32,
  parameter int XLEN = 64
);

  logic                mem_req;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [XLEN-1:0]     mem_wdata;
  logic [C_RLEN_W-1:0] mem_rlen;
  logic [C_WLEN_W-1:0] mem_wlen;
  logic                mem_ready;
  logic [XLEN-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_rlen, mem_wlen,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_rlen, mem_wlen,
    output mem_ready, mem_rdata
  );

endinterface : dbus_arbiter_if

`default_nettype wire

// File: rtl/dbus_starve_cnt.sv
// ---------------------------------------------------------------------------
// dbus_starve_cnt: saturating counter of core grants taken while aux waits.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dbus_starve_cnt
  import dbus_arbiter_pkg::*;
#(
  parameter int MAX = C_STARVE_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  inc,
  input  logic                  clr,
  output logic [C_STARVE_W-1:0] cnt,
  output logic                  at_max
);

  localparam logic [C_STARVE_W-1:0] C_MAX = C_STARVE_W'(MAX);
  localparam logic [C_STARVE_W-1:0] C_ONE = C_STARVE_W'(1);

  logic [C_STARVE_W-1:0] cnt_q;
  logic [C_STARVE_W-1:0] cnt_d;

  // Clear dominates so an aux grant always restarts the window.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_max) begin
      cnt_d = cnt_q + C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == C_MAX);
  assign cnt    = cnt_q;

endmodule : dbus_starve_cnt

`default_nettype wire

// File: rtl/dbus_arbiter.sv
// ---------------------------------------------------------------------------
// dbus_arbiter: shares the data-memory port between the core MEM stage and an
// aux master; DBUS_ARB_LOCK_EN adds core_lock to fence aux off the bus.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int XLEN       = 64,
  parameter int STARVE_MAX = C_STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  // core MEM stage
  input  logic                core_rd_en,
  input  logic                core_wr_en,
  input  logic [AW-1:0]       core_addr,
  input  logic [XLEN-1:0]     core_wdata,
  input  logic [C_RLEN_W-1:0] core_rlen,
  input  logic [C_WLEN_W-1:0] core_wlen,
  output logic                core_hold,
  output logic [XLEN-1:0]     core_rdata,
`ifdef DBUS_ARB_LOCK_EN
  input  logic                core_lock,
`endif
  // auxiliary master
  input  logic                aux_req,
  input  logic                aux_we,
  input  logic [AW-1:0]       aux_addr,
  input  logic [XLEN-1:0]     aux_wdata,
  input  logic [C_RLEN_W-1:0] aux_rlen,
  input  logic [C_WLEN_W-1:0] aux_wlen,
  output logic                aux_gnt,
  output logic                aux_done,
  output logic [XLEN-1:0]     aux_rdata,
  // data memory
  dbus_arbiter_if.master      mem
);

  arb_state_e state_q, state_d;

  logic                mem_req_q,   mem_req_d;
  logic                mem_we_q,    mem_we_d;
  logic [AW-1:0]       mem_addr_q,  mem_addr_d;
  logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
  logic [C_RLEN_W-1:0] mem_rlen_q,  mem_rlen_d;
  logic [C_WLEN_W-1:0] mem_wlen_q,  mem_wlen_d;
  logic [XLEN-1:0]     core_rdata_q, core_rdata_d;
  logic [XLEN-1:0]     aux_rdata_q,  aux_rdata_d;
  logic                aux_gnt_q,   aux_gnt_d;
  logic                aux_done_q,  aux_done_d;

  logic                  core_req;
  logic                  in_idle;
  logic                  aux_blocked;
  logic                  aux_win;
  logic                  core_win;
  logic                  starve_inc;
  logic                  starve_clr;
  logic                  starve_at_max;
  logic [C_STARVE_W-1:0] starve_cnt;

  assign core_req = core_rd_en | core_wr_en;
  assign in_idle  = (state_q == ST_IDLE);

`ifdef DBUS_ARB_LOCK_EN
  assign aux_blocked = core_lock;
`else
  assign aux_blocked = 1'b0;
`endif

  // Core has fixed priority except when aux has waited out the starvation window.
  assign aux_win  = in_idle & aux_req & ~aux_blocked & (~core_req | starve_at_max);
  assign core_win = in_idle & core_req & ~aux_win;

  assign starve_inc = core_win & aux_req;
  assign starve_clr = aux_win | ~aux_req;

  dbus_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .cnt    (starve_cnt),
    .at_max (starve_at_max)
  );

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_rlen_d   = mem_rlen_q;
    mem_wlen_d   = mem_wlen_q;
    core_rdata_d = core_rdata_q;
    aux_rdata_d  = aux_rdata_q;
    aux_gnt_d    = 1'b0;
    aux_done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (aux_win) begin
          state_d     = ST_BUSY_AUX;
          mem_req_d   = 1'b1;
          mem_we_d    = aux_we;
          mem_addr_d  = aux_addr;
          mem_wdata_d = aux_wdata;
          mem_rlen_d  = aux_rlen;
          mem_wlen_d  = aux_wlen;
          aux_gnt_d   = 1'b1;
        end else if (core_win) begin
          // A simultaneous read and write enable resolves to the write.
          state_d     = ST_BUSY_CORE;
          mem_req_d   = 1'b1;
          mem_we_d    = core_wr_en;
          mem_addr_d  = core_addr;
          mem_wdata_d = core_wdata;
          mem_rlen_d  = core_rlen;
          mem_wlen_d  = core_wlen;
        end
      end
      ST_BUSY_CORE: begin
        if (mem.mem_ready) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            core_rdata_d = mem.mem_rdata;
          end
        end
      end
      ST_BUSY_AUX: begin
        if (mem.mem_ready) begin
          state_d    = ST_IDLE;
          mem_req_d  = 1'b0;
          aux_done_d = 1'b1;
          if (!mem_we_q) begin
            aux_rdata_d = mem.mem_rdata;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_rlen_q   <= '0;
      mem_wlen_q   <= '0;
      core_rdata_q <= '0;
      aux_rdata_q  <= '0;
      aux_gnt_q    <= 1'b0;
      aux_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_rlen_q   <= mem_rlen_d;
      mem_wlen_q   <= mem_wlen_d;
      core_rdata_q <= core_rdata_d;
      aux_rdata_q  <= aux_rdata_d;
      aux_gnt_q    <= aux_gnt_d;
      aux_done_q   <= aux_done_d;
    end
  end

  // Hold drops in the very cycle the core's access completes so the pipeline advances.
  assign core_hold = rstn & core_req & ~((state_q == ST_BUSY_CORE) & mem.mem_ready);

  assign core_rdata    = core_rdata_q;
  assign aux_rdata     = aux_rdata_q;
  assign aux_gnt       = aux_gnt_q;
  assign aux_done      = aux_done_q;

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_rlen  = mem_rlen_q;
  assign mem.mem_wlen  = mem_wlen_q;

endmodule : dbus_arbiter

`default_nettype wire

// File: tb/tb_dbus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dbus_arbiter: directed self-checking bench for dbus_arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dbus_arbiter;
  import dbus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        core_rd_en, core_wr_en;
  logic [31:0] core_addr;
  logic [63:0] core_wdata;
  logic [2:0]  core_rlen;
  logic [1:0]  core_wlen;
  logic        core_hold;
  logic [63:0] core_rdata;
`ifdef DBUS_ARB_LOCK_EN
  logic        core_lock;
`endif
  logic        aux_req, aux_we;
  logic [31:0] aux_addr;
  logic [63:0] aux_wdata;
  logic [2:0]  aux_rlen;
  logic [1:0]  aux_wlen;
  logic        aux_gnt, aux_done;
  logic [63:0] aux_rdata;

  dbus_arbiter_if #(.AW(32), .XLEN(64)) mem_bus ();

  always #5 clk = ~clk;

  dbus_arbiter #(.AW(32), .XLEN(64), .STARVE_MAX(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .core_rd_en (core_rd_en),
    .core_wr_en (core_wr_en),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rlen  (core_rlen),
    .core_wlen  (core_wlen),
    .core_hold  (core_hold),
    .core_rdata (core_rdata),
`ifdef DBUS_ARB_LOCK_EN
    .core_lock  (core_lock),
`endif
    .aux_req    (aux_req),
    .aux_we     (aux_we),
    .aux_addr   (aux_addr),
    .aux_wdata  (aux_wdata),
    .aux_rlen   (aux_rlen),
    .aux_wlen   (aux_wlen),
    .aux_gnt    (aux_gnt),
    .aux_done   (aux_done),
    .aux_rdata  (aux_rdata),
    .mem        (mem_bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  localparam logic [63:0] C_LD_DATA = 64'h1122_3344_5566_7788;
  localparam logic [63:0] C_ST_DATA = 64'hA5A5_5A5A_0F0F_F0F0;

  initial begin
    int hold_cnt;
    int gidx;
    int aux_seen;
    logic prev_req;

    rstn = 1'b0; core_rd_en = 1'b0; core_wr_en = 1'b0;
    core_addr = '0; core_wdata = '0; core_rlen = '0; core_wlen = '0;
`ifdef DBUS_ARB_LOCK_EN
    core_lock = 1'b0;
`endif
    aux_req = 1'b0; aux_we = 1'b0; aux_addr = '0; aux_wdata = '0;
    aux_rlen = '0; aux_wlen = '0;
    mem_bus.mem_ready = 1'b0; mem_bus.mem_rdata = '0;

    // Reset: hold forced low even with a request present
    @(negedge clk); core_rd_en = 1'b1; #1;
    chk("rst_hold_forced", 64'(core_hold), 64'd0);
    @(negedge clk); #1;
    chk("rst_mem_req", 64'(mem_bus.mem_req), 64'd0);
    chk("rst_core_rdata", core_rdata, 64'd0);
    chk("rst_aux_gnt", 64'(aux_gnt), 64'd0);
    chk("rst_state", 64'(dut.state_q), 64'(ST_IDLE));
    chk("rst_starve", 64'(dut.starve_cnt), 64'd0);

    // Core load, ready in the first request cycle
    @(negedge clk);
    rstn = 1'b1; core_rd_en = 1'b1; core_addr = 32'h0000_1000; core_rlen = 3'd3; #1;
    chk("ld_hold_N", 64'(core_hold), 64'd1);
    chk("ld_req_N", 64'(mem_bus.mem_req), 64'd0);
    @(negedge clk);
    mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = C_LD_DATA; #1;
    chk("ld_req_N1", 64'(mem_bus.mem_req), 64'd1);
    chk("ld_we", 64'(mem_bus.mem_we), 64'd0);
    chk("ld_addr", 64'(mem_bus.mem_addr), 64'h1000);
    chk("ld_rlen", 64'(mem_bus.mem_rlen), 64'd3);
    chk("ld_hold_N1", 64'(core_hold), 64'd0);
    @(negedge clk);
    mem_bus.mem_ready = 1'b0; core_rd_en = 1'b0; #1;
    chk("ld_rdata_N2", core_rdata, C_LD_DATA);
    chk("ld_req_N2", 64'(mem_bus.mem_req), 64'd0);

    // Core store with three wait states
    @(negedge clk);
    core_wr_en = 1'b1; core_addr = 32'h0000_2008; core_wdata = C_ST_DATA; core_wlen = 2'd3;
    mem_bus.mem_rdata = 64'hFFFF_0000_0000_0BAD; #1;
    hold_cnt = core_hold ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (core_hold) hold_cnt++;
      chk($sformatf("st_req_w%0d", i), 64'(mem_bus.mem_req), 64'd1);
      chk($sformatf("st_we_w%0d", i), 64'(mem_bus.mem_we), 64'd1);
      chk($sformatf("st_wdata_w%0d", i), mem_bus.mem_wdata, C_ST_DATA);
    end
    @(negedge clk);
    mem_bus.mem_ready = 1'b1; #1;
    chk("st_hold_ready", 64'(core_hold), 64'd0);
    chk("st_wdata_ready", mem_bus.mem_wdata, C_ST_DATA);
    chk("st_wlen", 64'(mem_bus.mem_wlen), 64'd3);
    @(negedge clk);
    mem_bus.mem_ready = 1'b0; core_wr_en = 1'b0; #1;
    chk("st_hold_cycles", 64'(hold_cnt), 64'd4);
    chk("st_rdata_kept", core_rdata, C_LD_DATA);
    chk("st_req_done", 64'(mem_bus.mem_req), 64'd0);

    // Aux read alone
    @(negedge clk);
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h0000_0040; aux_rlen = 3'd2; #1;
    chk("ax_hold_N", 64'(core_hold), 64'd0);
    chk("ax_gnt_N", 64'(aux_gnt), 64'd0);
    @(negedge clk); #1;
    chk("ax_gnt_N1", 64'(aux_gnt), 64'd1);
    chk("ax_req", 64'(mem_bus.mem_req), 64'd1);
    chk("ax_addr", 64'(mem_bus.mem_addr), 64'h40);
    aux_req = 1'b0; mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 64'hDEAD; #1;
    chk("ax_hold_busy", 64'(core_hold), 64'd0);
    @(negedge clk);
    mem_bus.mem_ready = 1'b0; #1;
    chk("ax_done", 64'(aux_done), 64'd1);
    chk("ax_rdata", aux_rdata, 64'hDEAD);
    chk("ax_gnt_low", 64'(aux_gnt), 64'd0);
    chk("ax_core_rdata_kept", core_rdata, C_LD_DATA);
    @(negedge clk); #1;
    chk("ax_done_pulse", 64'(aux_done), 64'd0);

    // Starvation: both masters continuously requesting
    @(negedge clk);
    core_rd_en = 1'b1; core_addr = 32'h0000_3000;
    aux_req = 1'b1; aux_addr = 32'h0000_4000; #1;
    prev_req = 1'b0;
    gidx = 0;
    for (int cyc = 0; cyc < 40 && gidx < 10; cyc++) begin
      @(negedge clk); #1;
      if (mem_bus.mem_req && !prev_req) begin
        chk($sformatf("sv_gnt_g%0d", gidx), 64'(aux_gnt), (gidx % 5 == 4) ? 64'd1 : 64'd0);
        chk($sformatf("sv_addr_g%0d", gidx), 64'(mem_bus.mem_addr),
            (gidx % 5 == 4) ? 64'h4000 : 64'h3000);
        gidx++;
      end
      prev_req = mem_bus.mem_req;
      mem_bus.mem_ready = mem_bus.mem_req;
    end
    chk("sv_grant_count", 64'(gidx), 64'd10);
    @(negedge clk);
    mem_bus.mem_ready = 1'b0; core_rd_en = 1'b0; aux_req = 1'b0;
    @(negedge clk); #1;

    // Reset while a core access is outstanding
    core_rd_en = 1'b1; aux_req = 1'b1;
    @(negedge clk); #1;
    chk("rb_state_busy", 64'(dut.state_q), 64'(ST_BUSY_CORE));
    chk("rb_starve_pre", 64'(dut.starve_cnt), 64'd1);
    rstn = 1'b0; #1;
    chk("rb_hold_rst", 64'(core_hold), 64'd0);
    @(negedge clk); #1;
    chk("rb_mem_req", 64'(mem_bus.mem_req), 64'd0);
    chk("rb_state_idle", 64'(dut.state_q), 64'(ST_IDLE));
    chk("rb_starve_clr", 64'(dut.starve_cnt), 64'd0);
    chk("rb_hold", 64'(core_hold), 64'd0);
    core_rd_en = 1'b0; aux_req = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

`ifdef DBUS_ARB_LOCK_EN
    // Lock keeps aux off even with the starvation counter saturated
    @(negedge clk);
    core_lock = 1'b1; core_rd_en = 1'b1; core_addr = 32'h0000_5000;
    aux_req = 1'b1; aux_addr = 32'h0000_6000; #1;
    prev_req = 1'b0; gidx = 0; aux_seen = 0;
    for (int cyc = 0; cyc < 30 && gidx < 6; cyc++) begin
      @(negedge clk); #1;
      if (aux_gnt) aux_seen++;
      if (mem_bus.mem_req && !prev_req) gidx++;
      prev_req = mem_bus.mem_req;
      mem_bus.mem_ready = mem_bus.mem_req;
    end
    chk("lk_core_grants", 64'(gidx), 64'd6);
    chk("lk_no_aux", 64'(aux_seen), 64'd0);
    @(negedge clk);
    mem_bus.mem_ready = 1'b0; #1;
    chk("lk_starve_sat", 64'(dut.starve_cnt), 64'd4);
    core_lock = 1'b0;
    @(negedge clk); #1;
    chk("lk_aux_gnt", 64'(aux_gnt), 64'd1);
    chk("lk_aux_addr", 64'(mem_bus.mem_addr), 64'h6000);
    mem_bus.mem_ready = 1'b1; aux_req = 1'b0; core_rd_en = 1'b0;
    @(negedge clk);
    mem_bus.mem_ready = 1'b0;
`else
    aux_seen = 0;
    gidx = aux_seen;
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d checks expected completion", n_checks);
    $fatal(1, "timeout");
  end

endmodule : tb_dbus_arbiter

`default_nettype wire
